// File: rtl/io_input_bank.sv
// rtl/io_input_bank.sv - synchronized input port bank with change flags and optional debounce
// Optional feature macro: IO_INPUT_BANK_DEBOUNCE_EN (per-port debounce of DEB_CYCLES cycles).
// Without the macro each port follows its synchronized pins with a fixed three-edge latency.
module io_input_bank #(
  parameter int NPORTS     = 2,
  parameter int PW         = 10,
  parameter int DEB_CYCLES = 4
) (
  input  logic                 io_clk,
  input  logic                 reset,
  input  logic [31:0]          addr,
  input  logic                 rd,
  input  logic [NPORTS*PW-1:0] in_port,
  output logic [31:0]          io_read_data,
  output logic                 irq
);

  // Count value on which a held pin value is accepted into stable.
  localparam logic [15:0] DEB_LAST   = 16'(DEB_CYCLES - 1);
  // Word index of the change-flag status register, directly after the port registers.
  localparam logic [5:0]  STATUS_IDX = 6'(NPORTS);

  logic [NPORTS-1:0][PW-1:0] sync1_q, sync1_d;
  logic [NPORTS-1:0][PW-1:0] sync2_q, sync2_d;
  logic [NPORTS-1:0][PW-1:0] stable_q, stable_d;
  logic [NPORTS-1:0]         chg_q, chg_d;
  logic [NPORTS-1:0]         set_chg;
  logic [5:0]                idx;
  logic                      status_rd;
  logic                      unused_addr;

  assign idx         = addr[7:2];
  assign status_rd   = rd && (idx == STATUS_IDX);
  assign unused_addr = ^{addr[31:8], addr[1:0]};

  // Two-flop synchronizer in front of everything else; pins are asynchronous.
  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
  end

`ifdef IO_INPUT_BANK_DEBOUNCE_EN
  logic [NPORTS-1:0][15:0] cnt_q, cnt_d;

  // Per-port debounce: count while sync2 disagrees with stable, accept after DEB_CYCLES,
  // and restart the count whenever sync2 is about to move to yet another value.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    set_chg  = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_LAST) begin
        stable_d[i] = sync2_q[i];
        set_chg[i]  = 1'b1;
        cnt_d[i]    = '0;
      end else if (sync1_q[i] != sync2_q[i]) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // Debounce counters; reset aborts any count in progress.
  always_ff @(posedge io_clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_deb;
  assign unused_deb = ^DEB_LAST;

  // No debounce: stable follows sync2 every cycle, flagging any value change.
  always_comb begin
    stable_d = sync2_q;
    set_chg  = '0;
    for (int i = 0; i < NPORTS; i++) begin
      set_chg[i] = (sync2_q[i] != stable_q[i]);
    end
  end
`endif

  // Change flags: a status read clears all, a same-edge new update still sets its bit.
  always_comb begin
    chg_d = chg_q;
    if (status_rd) begin
      chg_d = '0;
    end
    chg_d = chg_d | set_chg;
  end

  // Register state for synchronizers, stable values and change flags.
  always_ff @(posedge io_clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      chg_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      chg_q    <= chg_d;
    end
  end

  // Read decode: port words first, then the status word, zero elsewhere.
  always_comb begin
    io_read_data = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (idx == 6'(i)) begin
        io_read_data[PW-1:0] = stable_q[i];
      end
    end
    if (idx == STATUS_IDX) begin
      io_read_data[NPORTS-1:0] = chg_q;
    end
  end

  assign irq = |chg_q;

endmodule
